// File: rtl/snake_tile_renderer.sv
// Snake/food compositor built on a double-buffered tile occupancy map.
// A build FSM fills the back map once per frame; a fixed 2-stage pipeline colours pixels from the front map.
module snake_tile_renderer #(
   parameter int GRID_W   = 10,
   parameter int GRID_H   = 10,
   parameter int TILE     = 40,
   parameter int BOARD_X0 = 48,
   parameter int BOARD_Y0 = 48,
   parameter int MAX_SEG  = 100,
   parameter int COORD_W  = 32
) (
   input  logic                       clk25,
   input  logic                       reset,
   input  logic                       screenEnd,
   input  logic                       active,
   input  logic [31:0]                x,
   input  logic [31:0]                y,
   input  logic [MAX_SEG*COORD_W-1:0] seg_x,
   input  logic [MAX_SEG*COORD_W-1:0] seg_y,
   input  logic [COORD_W-1:0]         food_x,
   input  logic [COORD_W-1:0]         food_y,
   input  logic [11:0]                bg_color,
   input  logic [11:0]                head_color,
   input  logic [11:0]                body_color,
   input  logic [11:0]                food_color,
   output logic [11:0]                color_out,
   output logic                       out_valid,
   output logic                       busy,
   output logic                       self_hit,
   output logic                       oob,
   output logic                       frame_drop
);

   localparam int CELLS  = GRID_W * GRID_H;
   localparam int IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int SLOT_W = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;
   localparam int COL_W  = (GRID_W > 1) ? $clog2(GRID_W) : 1;
   localparam int ROW_W  = (GRID_H > 1) ? $clog2(GRID_H) : 1;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_BODY  = 2'b01;
   localparam logic [1:0] CELL_HEAD  = 2'b10;
   localparam logic [1:0] CELL_FOOD  = 2'b11;

   typedef enum logic [1:0] {ST_CLEAR, ST_SCAN, ST_DONE} state_t;

   state_t               state, state_nx;
   logic                 sel;
   logic                 back_sel;
   logic [1:0]           map [2][CELLS];
   logic [SLOT_W-1:0]    slot;
   logic                 hit, flag;
   logic [COORD_W-1:0]   head_x, head_y;

   logic [COORD_W-1:0]   sx, sy;
   logic                 absent, slot_off, slot_hit, last_slot, food_in;
   logic [IDX_W-1:0]     slot_idx, food_idx;

   assign back_sel  = ~sel;
   assign busy      = (state != ST_DONE);
   assign sx        = seg_x[COORD_W*slot +: COORD_W];
   assign sy        = seg_y[COORD_W*slot +: COORD_W];
   assign absent    = (sx == '1) || (sy == '1);
   assign slot_off  = !absent && (sx >= COORD_W'(GRID_W) || sy >= COORD_W'(GRID_H));
   assign slot_hit  = !absent && !slot_off && (slot != '0) && (sx == head_x) && (sy == head_y);
   assign last_slot = (slot == SLOT_W'(MAX_SEG - 1));
   assign slot_idx  = IDX_W'(sy) * IDX_W'(GRID_W) + IDX_W'(sx);
   assign food_in   = (food_x < COORD_W'(GRID_W)) && (food_y < COORD_W'(GRID_H));
   assign food_idx  = IDX_W'(food_y) * IDX_W'(GRID_W) + IDX_W'(food_x);

   always_ff @(posedge clk25) begin
      if (reset) state <= ST_CLEAR;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_CLEAR: state_nx = ST_SCAN;
         ST_SCAN:  if (absent || last_slot) state_nx = ST_DONE;
         ST_DONE:  if (screenEnd) state_nx = ST_CLEAR;
         default:  state_nx = ST_CLEAR;
      endcase
   end

   // NOTE: the maps are reset on purpose so the first frame after reset is blank;
   // all state here uses <= so every read sees the pre-edge value.
   always_ff @(posedge clk25) begin
      if (reset) begin
         sel        <= 1'b0;
         slot       <= '0;
         hit        <= 1'b0;
         flag       <= 1'b0;
         head_x     <= '0;
         head_y     <= '0;
         self_hit   <= 1'b0;
         oob        <= 1'b0;
         frame_drop <= 1'b0;
         for (int b = 0; b < 2; b++)
            for (int c = 0; c < CELLS; c++)
               map[b][c] <= CELL_EMPTY;
      end else begin
         frame_drop <= screenEnd && busy;
         case (state)
            ST_CLEAR: begin
               for (int c = 0; c < CELLS; c++)
                  map[back_sel][c] <= CELL_EMPTY;
               if (food_in) map[back_sel][food_idx] <= CELL_FOOD;
               flag <= !food_in;
               hit  <= 1'b0;
               slot <= '0;
            end
            ST_SCAN: begin
               if (!absent) begin
                  if (slot == '0) begin
                     head_x <= sx;
                     head_y <= sy;
                  end
                  // Body segments never cover the head; both cover food.
                  if (!slot_off && (slot == '0 || map[back_sel][slot_idx] != CELL_HEAD))
                     map[back_sel][slot_idx] <= (slot == '0) ? CELL_HEAD : CELL_BODY;
                  slot <= slot + 1'b1;
                  hit  <= hit | slot_hit;
                  flag <= flag | slot_off;
               end
               if (absent || last_slot) begin
                  self_hit <= hit | slot_hit;
                  oob      <= flag | slot_off;
               end
            end
            ST_DONE: if (screenEnd) sel <= ~sel;
            default: ;
         endcase
      end
   end

   // Pixel pipeline: stage 1 locates the tile, stage 2 looks it up and colours it.
   logic             in_x, in_y, in_d, active_d;
   logic [COL_W-1:0] col_d;
   logic [ROW_W-1:0] row_d;
   logic [IDX_W-1:0] front_idx;
   logic [1:0]       front_cell;
   logic [11:0]      pix_color;

   assign in_x = (x >= 32'(BOARD_X0)) && (x < 32'(BOARD_X0 + GRID_W*TILE));
   assign in_y = (y >= 32'(BOARD_Y0)) && (y < 32'(BOARD_Y0 + GRID_H*TILE));
   assign front_idx  = IDX_W'(row_d) * IDX_W'(GRID_W) + IDX_W'(col_d);
   assign front_cell = map[sel][front_idx];

   always_comb begin
      pix_color = bg_color;
      if (!active_d) pix_color = '0;
      else if (in_d) begin
         case (front_cell)
            CELL_HEAD: pix_color = head_color;
            CELL_BODY: pix_color = body_color;
            CELL_FOOD: pix_color = food_color;
            default:   pix_color = bg_color;
         endcase
      end
   end

   always_ff @(posedge clk25) begin
      if (reset) begin
         in_d      <= 1'b0;
         col_d     <= '0;
         row_d     <= '0;
         active_d  <= 1'b0;
         color_out <= '0;
         out_valid <= 1'b0;
      end else begin
         in_d      <= in_x && in_y;
         col_d     <= (in_x && in_y) ? COL_W'((x - 32'(BOARD_X0)) / 32'(TILE)) : '0;
         row_d     <= (in_x && in_y) ? ROW_W'((y - 32'(BOARD_Y0)) / 32'(TILE)) : '0;
         active_d  <= active;
         color_out <= pix_color;
         out_valid <= active_d;
      end
   end

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Directed bench for snake_tile_renderer: map build, swap, flags, pipeline latency and reset.
module tb_snake_tile_renderer;

   localparam int MAX_SEG = 100;
   localparam int COORD_W = 32;
   localparam logic [11:0] BG   = 12'h111;
   localparam logic [11:0] HEAD = 12'hF00;
   localparam logic [11:0] BODY = 12'h0F0;
   localparam logic [11:0] FOOD = 12'h00F;

   logic                       clk25 = 1'b0;
   logic                       reset, screenEnd, active;
   logic [31:0]                x, y;
   logic [MAX_SEG*COORD_W-1:0] seg_x, seg_y;
   logic [COORD_W-1:0]         food_x, food_y;
   logic [11:0]                bg_color, head_color, body_color, food_color;
   logic [11:0]                color_out;
   logic                       out_valid, busy, self_hit, oob, frame_drop;

   int checks   = 0;
   int failures = 0;

   snake_tile_renderer dut (
      .clk25(clk25), .reset(reset), .screenEnd(screenEnd), .active(active),
      .x(x), .y(y), .seg_x(seg_x), .seg_y(seg_y), .food_x(food_x), .food_y(food_y),
      .bg_color(bg_color), .head_color(head_color), .body_color(body_color),
      .food_color(food_color), .color_out(color_out), .out_valid(out_valid),
      .busy(busy), .self_hit(self_hit), .oob(oob), .frame_drop(frame_drop)
   );

   always #20 clk25 = ~clk25;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_segs();
      seg_x = '1;
      seg_y = '1;
   endtask

   task automatic set_seg(input int i, input int sx, input int sy);
      seg_x[COORD_W*i +: COORD_W] = sx;
      seg_y[COORD_W*i +: COORD_W] = sy;
   endtask

   task automatic wait_done();
      int n = 0;
      while (busy && n < 500) begin
         @(negedge clk25);
         n++;
      end
      check("wait_done", busy, 0);
   endtask

   task automatic pulse_end();
      @(negedge clk25) screenEnd = 1'b1;
      @(negedge clk25) screenEnd = 1'b0;
   endtask

   // Build the current data into the back map, check flags, then swap it to the front.
   task automatic new_frame(input string tag, input logic exp_hit, input logic exp_oob);
      wait_done();
      pulse_end();
      wait_done();
      check({tag, "_self_hit"}, self_hit, exp_hit);
      check({tag, "_oob"}, oob, exp_oob);
      pulse_end();
   endtask

   task automatic pixel(input string tag, input int px, input int py, input logic [11:0] exp);
      @(negedge clk25);
      x = px; y = py; active = 1'b1;
      @(negedge clk25);
      active = 1'b0;
      check({tag, "_valid_lat1"}, out_valid, 0);
      @(negedge clk25);
      check({tag, "_color"}, color_out, exp);
      check({tag, "_valid"}, out_valid, 1);
   endtask

   initial begin
      int n;
      reset = 1'b1; screenEnd = 1'b0; active = 1'b0; x = '0; y = '0;
      bg_color = BG; head_color = HEAD; body_color = BODY; food_color = FOOD;
      clear_segs();
      set_seg(0, 0, 0);
      set_seg(1, 1, 0);
      food_x = 5; food_y = 5;
      repeat (2) @(negedge clk25);
      check("rst_color", color_out, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 1);
      check("rst_self_hit", self_hit, 0);
      check("rst_oob", oob, 0);
      check("rst_frame_drop", frame_drop, 0);
      reset = 1'b0;

      // Basic compositing and tile boundaries
      new_frame("t1", 1'b0, 1'b0);
      pixel("t1_head", 48, 48, HEAD);
      pixel("t1_body", 90, 50, BODY);
      pixel("t1_food", 250, 250, FOOD);
      pixel("t1_bg", 10, 10, BG);
      pixel("t1_col0_last", 87, 48, HEAD);
      pixel("t1_col1_first", 88, 48, BODY);
      pixel("t1_left_of_board", 47, 48, BG);
      pixel("t1_right_of_board", 448, 448, BG);
      @(negedge clk25);
      x = 48; y = 48; active = 1'b0;
      repeat (2) @(negedge clk25);
      check("t1_inactive_color", color_out, 0);
      check("t1_inactive_valid", out_valid, 0);

      // Self-collision set, then cleared on the next build
      wait_done();
      clear_segs();
      set_seg(0, 3, 3); set_seg(1, 3, 4); set_seg(2, 3, 3);
      new_frame("t2", 1'b1, 1'b0);
      pixel("t2_head_kept", 173, 173, HEAD);
      pixel("t2_body", 173, 213, BODY);
      wait_done();
      set_seg(2, 4, 4);
      new_frame("t2b", 1'b0, 1'b0);
      pixel("t2b_body", 213, 213, BODY);

      // Off-grid segment and food
      wait_done();
      clear_segs();
      set_seg(0, 0, 0); set_seg(1, 10, 0); set_seg(2, 2, 0);
      food_x = 0; food_y = 10;
      new_frame("t3", 1'b0, 1'b1);
      pixel("t3_head", 53, 53, HEAD);
      pixel("t3_body", 133, 53, BODY);
      pixel("t3_no_alias", 53, 93, BG);
      pixel("t3_old_food_gone", 250, 250, BG);
      pixel("t3_bottom_row", 53, 413, BG);
      pixel("t3_old_head_gone", 173, 173, BG);

      // All slots valid: busy length and full coverage
      wait_done();
      for (int i = 0; i < MAX_SEG; i++) set_seg(i, i % 10, i / 10);
      food_x = 5; food_y = 5;
      wait_done();
      pulse_end();
      n = 0;
      while (busy && n < 500) begin
         n++;
         @(negedge clk25);
      end
      check("t4_busy_cycles", n, MAX_SEG + 1);
      check("t4_self_hit", self_hit, 0);
      check("t4_oob", oob, 0);
      pulse_end();
      pixel("t4_head", 53, 53, HEAD);
      pixel("t4_corner", 413, 413, BODY);
      pixel("t4_body_over_food", 253, 253, BODY);
      pixel("t4_top_right", 413, 53, BODY);

      // screenEnd during the build is dropped
      wait_done();
      clear_segs();
      for (int i = 0; i < 20; i++) set_seg(i, i % 10, i / 10);
      pulse_end();
      repeat (2) @(negedge clk25);
      screenEnd = 1'b1;
      @(negedge clk25);
      screenEnd = 1'b0;
      check("t5_frame_drop", frame_drop, 1);
      check("t5_busy", busy, 1);
      @(negedge clk25);
      check("t5_frame_drop_pulse", frame_drop, 0);
      pixel("t5_old_front", 253, 253, BODY);
      wait_done();
      pixel("t5_no_swap", 53, 133, BODY);
      pulse_end();
      pixel("t5_new_food", 253, 253, FOOD);
      pixel("t5_new_row1", 53, 93, BODY);
      pixel("t5_new_row2", 53, 133, BG);

      // Reset in the middle of a build
      wait_done();
      for (int i = 0; i < MAX_SEG; i++) set_seg(i, i % 10, i / 10);
      set_seg(50, 0, 0);
      new_frame("t6pre", 1'b1, 1'b0);
      wait_done();
      pulse_end();
      x = 48; y = 48; active = 1'b1;
      repeat (4) @(negedge clk25);
      check("t6_pre_valid", out_valid, 1);
      check("t6_pre_color", color_out, HEAD);
      check("t6_pre_busy", busy, 1);
      reset = 1'b1; active = 1'b0;
      @(negedge clk25);
      check("t6_rst_color", color_out, 0);
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_self_hit", self_hit, 0);
      check("t6_rst_busy", busy, 1);
      reset = 1'b0;
      pixel("t6_blank_head", 53, 53, BG);
      pixel("t6_blank_food", 253, 253, BG);
      pixel("t6_blank_corner", 413, 413, BG);
      wait_done();
      check("t6_rebuild_self_hit", self_hit, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
